wr_rd_burst_seq: RTL and testbench

Command sequencer that drives the wr/rd strobe pair consumed by the downstream memory-side stage and its protocol checker. Each accepted command produces:
- a one-cycle write pulse;
- a fixed gap;
- a read strobe held for 2–5 consecutive cycles;
- a mandatory idle cycle with rd low.

Commands are buffered in a small FIFO so the host can queue several transactions back to back.

---
 rtl/wr_rd_burst_seq_if.sv | 28 ++
 rtl/wr_rd_burst_seq.sv | 178 +++++++++++++++++
 tb/tb_wr_rd_burst_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_rd_burst_seq_if.sv
// Host command channel and memory-side wr/rd strobe bundle for wr_rd_burst_seq.
interface wr_rd_burst_seq_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [2:0]        cmd_len;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              len_clamped;

    modport master (
        output cmd_valid, cmd_addr, cmd_data, cmd_len,
        input  cmd_ready, wr, rd, mem_addr, mem_wdata, busy, done, len_clamped
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data, cmd_len,
        output cmd_ready, wr, rd, mem_addr, mem_wdata, busy, done, len_clamped
    );
endinterface

// File: rtl/wr_rd_burst_seq.sv
// Buffered command sequencer: per command a wr pulse, a fixed gap, a 2..5 cycle
// rd burst with incrementing address, then one idle/done cycle.
module wr_rd_burst_seq #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYC    = 1,
    parameter int MIN_RD     = 2,
    parameter int MAX_RD     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    wr_rd_burst_seq_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [2:0]       MIN_L    = 3'(MIN_RD);
    localparam logic [2:0]       MAX_L    = 3'(MAX_RD);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_READ,
        ST_TAIL
    } state_t;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [2:0]        fifo_len_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [2:0]        len_in;
    logic              len_clip;
    logic              len_clamped_q;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [2:0]        rdcnt_q, rdcnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              done_q, done_d;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = bus.cmd_valid && !fifo_full;

    always_comb begin
        len_in   = bus.cmd_len;
        len_clip = 1'b0;
        if (bus.cmd_len < MIN_L) begin
            len_in   = MIN_L;
            len_clip = 1'b1;
        end else if (bus.cmd_len > MAX_L) begin
            len_in   = MAX_L;
            len_clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= bus.cmd_addr;
            fifo_data_q[wptr_q] <= bus.cmd_data;
            fifo_len_q[wptr_q]  <= len_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            len_clamped_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            len_clamped_q <= push && len_clip;
        end
    end

    // Strobes are computed from the next state so every output is a flop.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        rdcnt_d = rdcnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE, ST_TAIL: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_WRITE;
                    addr_d  = fifo_addr_q[rptr_q];
                    wdata_d = fifo_data_q[rptr_q];
                    len_d   = fifo_len_q[rptr_q];
                    wr_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_READ;
                    rd_d    = 1'b1;
                    rdcnt_d = len_q - 3'd1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_READ: begin
                if (rdcnt_q == '0) begin
                    state_d = ST_TAIL;
                    done_d  = 1'b1;
                end else begin
                    rd_d    = 1'b1;
                    rdcnt_d = rdcnt_q - 3'd1;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            rdcnt_q <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rdcnt_q <= rdcnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.wr          = wr_q;
    assign bus.rd          = rd_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.done        = done_q;
    assign bus.len_clamped = len_clamped_q;
    assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_wr_rd_burst_seq.sv
// Scoreboard bench for wr_rd_burst_seq: accepted commands are queued with their
// push edge; a negedge monitor derives the expected strobe schedule from them.
module tb_wr_rd_burst_seq;
    localparam int G     = 1;
    localparam int DEPTH = 4;
    localparam int MINL  = 2;
    localparam int MAXL  = 5;

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  data;
        int          len;
        bit          clamped;
        int          push_edge;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    cmd_t exp_q[$];
    cmd_t cur;
    bit   cur_act = 1'b0;
    int   cur_w = 0;
    int   next_free = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    int   rd_run = 0;
    bit   prev_wr = 1'b0;
    bit   saw_full = 1'b0;

    wr_rd_burst_seq_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    wr_rd_burst_seq #(
        .ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(DEPTH),
        .GAP_CYC(G), .MIN_RD(MINL), .MAX_RD(MAXL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampl(input int l);
        if (l < MINL) return MINL;
        if (l > MAXL) return MAXL;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; the push lands on the next edge.
    task automatic send(input logic [3:0] a, input logic [7:0] d, input logic [2:0] l);
        int waitc = 0;
        cmd_t c;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_len   = l;
        while (!bus.cmd_ready && waitc < 200) begin
            tick();
            waitc++;
        end
        if (!bus.cmd_ready) begin
            chk("ready_timeout", {31'b0, bus.cmd_ready}, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        c.addr      = a;
        c.data      = d;
        c.len       = clampl(int'(l));
        c.clamped   = (int'(l) != c.len);
        c.push_edge = cyc + 1;
        exp_q.push_back(c);
        acc_cnt++;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || cur_act) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_timeout", {31'b0, (exp_q.size() > 0 || cur_act)}, 0);
        tick();
    endtask

    task automatic monitor_cycle();
        int   occ, off, w;
        logic ewr, erd, edone, eclamp;
        logic [3:0] ea;
        if (!cur_act && exp_q.size() > 0) begin
            w = (exp_q[0].push_edge + 1 > next_free) ? exp_q[0].push_edge + 1 : next_free;
            if (cyc == w) begin
                cur     = exp_q.pop_front();
                cur_act = 1'b1;
                cur_w   = cyc;
            end
        end
        occ = 0;
        eclamp = 1'b0;
        foreach (exp_q[i]) begin
            if (exp_q[i].push_edge <= cyc) occ++;
            if (exp_q[i].push_edge == cyc && exp_q[i].clamped) eclamp = 1'b1;
        end
        ewr = 1'b0; erd = 1'b0; edone = 1'b0; off = 0;
        if (cur_act) begin
            off = cyc - cur_w;
            if (off == 0) begin
                ewr = 1'b1;
                chk("wr_addr", {28'b0, bus.mem_addr}, {28'b0, cur.addr});
                chk("wr_data", {24'b0, bus.mem_wdata}, {24'b0, cur.data});
            end else if (off > G && off <= G + cur.len) begin
                erd = 1'b1;
                ea  = cur.addr + 4'(off - G - 1);
                chk("rd_addr", {28'b0, bus.mem_addr}, {28'b0, ea});
                chk("rd_wdata_hold", {24'b0, bus.mem_wdata}, {24'b0, cur.data});
            end else if (off == G + cur.len + 1) begin
                edone = 1'b1;
            end
        end
        chk("wr", {31'b0, bus.wr}, {31'b0, ewr});
        chk("rd", {31'b0, bus.rd}, {31'b0, erd});
        chk("done", {31'b0, bus.done}, {31'b0, edone});
        chk("len_clamped", {31'b0, bus.len_clamped}, {31'b0, eclamp});
        chk("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, (occ < DEPTH)});
        chk("busy", {31'b0, bus.busy}, {31'b0, (cur_act || occ != 0)});
        chk("wr_rd_excl", {31'b0, (bus.wr && bus.rd)}, 0);
        if (prev_wr) chk("wr_consec", {31'b0, bus.wr}, 0);
        prev_wr = bus.wr;
        if (bus.rd) rd_run++;
        else if (rd_run > 0) begin
            chk("rd_burst_len_ok", {31'b0, (rd_run >= MINL && rd_run <= MAXL)}, 1);
            rd_run = 0;
        end
        if (bus.done) done_cnt++;
        if (!bus.cmd_ready) saw_full = 1'b1;
        if (cur_act && off == G + cur.len + 1) begin
            cur_act   = 1'b0;
            next_free = cyc + 1;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) monitor_cycle();
                else begin
                    rd_run  = 0;
                    prev_wr = 1'b0;
                end
            end
        join_none

        repeat (3) tick();
        chk("rst_wr", {31'b0, bus.wr}, 0);
        chk("rst_rd", {31'b0, bus.rd}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_ready", {31'b0, bus.cmd_ready}, 1);
        chk("rst_addr", {28'b0, bus.mem_addr}, 0);
        chk("rst_wdata", {24'b0, bus.mem_wdata}, 0);
        rst_n = 1'b1;
        tick();

        // single command
        send(4'd3, 8'hA5, 3'd3);
        drain();
        chk("t1_busy_after", {31'b0, bus.busy}, 0);

        // length clamp both ways
        send(4'd0, 8'h11, 3'd0);
        drain();
        send(4'd0, 8'h22, 3'd7);
        drain();

        // address wrap
        send(4'hE, 8'h5A, 3'd4);
        drain();

        // fill the FIFO behind a running command
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++)
            send(4'(i * 3), 8'(8'h40 + i), 3'(2 + (i % 4)));
        drain();
        chk("t4_ready_dropped", {31'b0, saw_full}, 1);
        chk("t4_done_count", done_cnt, acc_cnt);

        // reset during the second rd cycle of a 5-cycle burst
        send(4'd5, 8'h3C, 3'd5);
        for (int n = 0; n < 20 && !bus.rd; n++) tick();
        chk("t5_rd_seen", {31'b0, bus.rd}, 1);
        tick();
        chk("t5_rd_second", {31'b0, bus.rd}, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        cur_act   = 1'b0;
        next_free = 0;
        acc_cnt   = 0;
        done_cnt  = 0;
        chk("t5_rd_async", {31'b0, bus.rd}, 0);
        chk("t5_wr_async", {31'b0, bus.wr}, 0);
        chk("t5_ready", {31'b0, bus.cmd_ready}, 1);
        chk("t5_busy", {31'b0, bus.busy}, 0);
        chk("t5_addr", {28'b0, bus.mem_addr}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t5_quiet_busy", {31'b0, bus.busy}, 0);

        // random stream
        for (int i = 0; i < 500; i++) begin
            int gap;
            send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            repeat (gap) tick();
        end
        drain();
        chk("t6_done_count", done_cnt, acc_cnt);
        chk("t6_idle_busy", {31'b0, bus.busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
